// File: rtl/cpu_ctrl_pkg.sv
// Shared state, opcode and trap-cause definitions for the multicycle control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } ctrl_state_e;

  typedef enum logic [1:0] {
    TC_NONE          = 2'd0,
    TC_FETCH_TIMEOUT = 2'd1,
    TC_MISALIGNED    = 2'd2,
    TC_ILLEGAL       = 2'd3
  } trap_cause_e;

  typedef enum logic [1:0] {
    CL_RTYPE   = 2'd0,
    CL_ITYPE   = 2'd1,
    CL_BRANCH  = 2'd2,
    CL_ILLEGAL = 2'd3
  } instr_class_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] FUNC7_SUB = 7'b0100000;

  // Only BEQ (000) and BNE (001) are legal branch encodings.
  function automatic instr_class_e classify(input logic [6:0] opcode, input logic [2:0] func3);
    instr_class_e cls;
    case (opcode)
      OP_RTYPE:  cls = CL_RTYPE;
      OP_ITYPE:  cls = CL_ITYPE;
      OP_BRANCH: cls = (func3[2:1] == 2'b00) ? CL_BRANCH : CL_ILLEGAL;
      default:   cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_imm_gen.sv
// Immediate generator: sign-extended I-type or B-type immediate selected by opcode.
module imm_gen
  import cpu_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic unused_funct_bits;
  assign unused_funct_bits = ^instr[19:12];

  // Opcode-selected immediate; R-type and unknown opcodes carry none.
  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_ITYPE:  imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OP_BRANCH: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/WB for R-type, I-type ALU, BEQ and BNE.
// Define INSTR_COUNT_EN to build the retired-instruction counter on instret.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int              XLEN          = 64,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 16
) (
  input  logic            Clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  output logic [4:0]      rf_rd,
  output logic            rf_we,
  output logic [6:0]      alu_opcode,
  output logic [2:0]      alu_func3,
  output logic [6:0]      alu_func7,
  output logic            alu_b_imm,
  output logic [XLEN-1:0] imm,
  input  logic            alu_zero,
  output logic [XLEN-1:0] pc,
  output logic            busy,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [63:0]     instret
);

  localparam int             TCW       = $clog2(FETCH_TIMEOUT) + 1;
  localparam logic [TCW-1:0] TCNT_LAST = TCW'(FETCH_TIMEOUT - 1);

  ctrl_state_e     state_r;
  instr_class_e    cls_r;
  logic            br_ne_r;
  logic            taken_r;
  logic [TCW-1:0]  tcnt_r;

  instr_class_e    dec_cls_s;
  logic [6:0]      dec_opcode_s;
  logic [2:0]      dec_func3_s;
  logic [6:0]      dec_func7_s;
  logic            dec_b_imm_s;
  logic [XLEN-1:0] dec_imm_s;
  logic [XLEN-1:0] target_s;
  logic            misalign_s;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (imem_rdata),
    .imm   (dec_imm_s)
  );

  assign imem_addr  = pc;
  assign target_s   = pc + imm;
  assign misalign_s = taken_r && (target_s[1:0] != 2'b00);

  // ALU control fields for the word arriving on imem_rdata; branches compare via SUB.
  always_comb begin
    dec_cls_s    = classify(imem_rdata[6:0], imem_rdata[14:12]);
    dec_opcode_s = 7'd0;
    dec_func3_s  = 3'd0;
    dec_func7_s  = 7'd0;
    dec_b_imm_s  = 1'b0;
    case (dec_cls_s)
      CL_RTYPE: begin
        dec_opcode_s = imem_rdata[6:0];
        dec_func3_s  = imem_rdata[14:12];
        dec_func7_s  = imem_rdata[31:25];
      end
      CL_ITYPE: begin
        dec_opcode_s = OP_ITYPE;
        dec_func3_s  = imem_rdata[14:12];
        dec_func7_s  = (imem_rdata[14:12] == 3'b101) ? imem_rdata[31:25] : 7'd0;
        dec_b_imm_s  = 1'b1;
      end
      CL_BRANCH: begin
        dec_opcode_s = OP_RTYPE;
        dec_func3_s  = 3'b000;
        dec_func7_s  = FUNC7_SUB;
      end
      default: begin
        dec_opcode_s = 7'd0;
      end
    endcase
  end

  // Sequencer FSM; every output is registered on the transition into the state that owns it.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      pc         <= RESET_PC;
      cls_r      <= CL_ILLEGAL;
      br_ne_r    <= 1'b0;
      taken_r    <= 1'b0;
      tcnt_r     <= '0;
      imem_req   <= 1'b0;
      rf_rs1     <= 5'd0;
      rf_rs2     <= 5'd0;
      rf_rd      <= 5'd0;
      rf_we      <= 1'b0;
      alu_opcode <= 7'd0;
      alu_func3  <= 3'd0;
      alu_func7  <= 7'd0;
      alu_b_imm  <= 1'b0;
      imm        <= '0;
      busy       <= 1'b0;
      trap       <= 1'b0;
      trap_cause <= TC_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run) begin
            state_r  <= ST_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            state_r    <= ST_DECODE;
            imem_req   <= 1'b0;
            tcnt_r     <= '0;
            cls_r      <= dec_cls_s;
            br_ne_r    <= imem_rdata[12];
            rf_rs1     <= imem_rdata[19:15];
            rf_rs2     <= imem_rdata[24:20];
            rf_rd      <= imem_rdata[11:7];
            alu_opcode <= dec_opcode_s;
            alu_func3  <= dec_func3_s;
            alu_func7  <= dec_func7_s;
            alu_b_imm  <= dec_b_imm_s;
            imm        <= dec_imm_s;
          end else if (tcnt_r == TCNT_LAST) begin
            state_r    <= ST_TRAP;
            imem_req   <= 1'b0;
            busy       <= 1'b0;
            trap       <= 1'b1;
            trap_cause <= TC_FETCH_TIMEOUT;
          end else begin
            tcnt_r <= tcnt_r + TCW'(1);
          end
        end
        ST_DECODE: begin
          if (cls_r == CL_ILLEGAL) begin
            state_r    <= ST_TRAP;
            busy       <= 1'b0;
            trap       <= 1'b1;
            trap_cause <= TC_ILLEGAL;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_r <= ST_WB;
          taken_r <= (cls_r == CL_BRANCH) && (br_ne_r ? !alu_zero : alu_zero);
          rf_we   <= ((cls_r == CL_RTYPE) || (cls_r == CL_ITYPE)) && (rf_rd != 5'd0);
        end
        ST_WB: begin
          rf_we <= 1'b0;
          if (misalign_s) begin
            state_r    <= ST_TRAP;
            busy       <= 1'b0;
            trap       <= 1'b1;
            trap_cause <= TC_MISALIGNED;
          end else begin
            pc       <= taken_r ? target_s : pc + XLEN'(4);
            state_r  <= run ? ST_FETCH : ST_IDLE;
            imem_req <= run;
            busy     <= run;
          end
        end
        ST_TRAP: begin
          state_r <= ST_TRAP;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef INSTR_COUNT_EN
  // A writeback retires its instruction unless it ends in a misaligned-target trap.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      instret <= 64'd0;
    end else if ((state_r == ST_WB) && !misalign_s) begin
      instret <= instret + 64'd1;
    end
  end
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected decode/writeback results are queued at fetch.
module tb_multicycle_ctrl;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        Clk = 1'b0;
  logic        rst, run, imem_req, imem_ack, rf_we, alu_b_imm, alu_zero, busy, trap;
  logic [63:0] imem_addr, imm, pc, instret;
  logic [31:0] imem_rdata;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [6:0]  alu_opcode, alu_func7;
  logic [2:0]  alu_func3;
  logic [1:0]  trap_cause;

  multicycle_ctrl #(.XLEN(64), .RESET_PC(RST_PC), .FETCH_TIMEOUT(16)) dut (
    .Clk(Clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rd(rf_rd), .rf_we(rf_we), .alu_opcode(alu_opcode), .alu_func3(alu_func3),
    .alu_func7(alu_func7), .alu_b_imm(alu_b_imm), .imm(imm), .alu_zero(alu_zero),
    .pc(pc), .busy(busy), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic        b_imm, chk_imm, chk_alu, we;
    logic [1:0]  cause;
    logic [63:0] imm, next_pc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          retired = 0;
  logic [63:0] model_pc;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [63:0] exp_instret();
`ifdef INSTR_COUNT_EN
    return 64'(retired);
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm12, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] o);
    return {o[12], o[10:5], 5'd2, 5'd1, f3, o[4:1], o[11], 7'b1100011};
  endfunction

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; imem_ack = 1'b0; alu_zero = 1'b0; imem_rdata = 32'd0;
    tick();
    check_val("rst_pc", pc, RST_PC);
    check_val("rst_req", 64'(imem_req), 64'd0);
    check_val("rst_we", 64'(rf_we), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_trap", 64'({trap, trap_cause}), 64'd0);
    check_val("rst_fields", 64'({rf_rs1, rf_rs2, rf_rd, alu_opcode, alu_func3, alu_func7, alu_b_imm}), 64'd0);
    check_val("rst_imm", imm, 64'd0);
    check_val("rst_instret", instret, 64'd0);
    model_pc = RST_PC;
    retired  = 0;
    sb_q.delete();
    rst = 1'b1;
  endtask

  task automatic exec(input logic [31:0] instr, input exp_t e, input logic zero, input int delay,
                      input logic drop_run);
    int   n;
    exp_t got;
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check_val("fetch_req", 64'(imem_req), 64'd1);
    check_val("fetch_addr", imem_addr, e.pc);
    for (int i = 0; i < delay; i++) begin
      tick();
      check_val("fetch_wait", 64'({trap, imem_req}), 64'd1);
    end
    imem_ack = 1'b1; imem_rdata = instr; alu_zero = zero;
    sb_q.push_back(e);
    tick();
    imem_ack = 1'b0;
    got = sb_q.pop_front();
    check_val("dec_rs1", 64'(rf_rs1), 64'(got.rs1));
    check_val("dec_rs2", 64'(rf_rs2), 64'(got.rs2));
    check_val("dec_rd", 64'(rf_rd), 64'(got.rd));
    if (got.chk_alu) begin
      check_val("dec_opcode", 64'(alu_opcode), 64'(got.op));
      check_val("dec_func3", 64'(alu_func3), 64'(got.f3));
      check_val("dec_func7", 64'(alu_func7), 64'(got.f7));
      check_val("dec_b_imm", 64'(alu_b_imm), 64'(got.b_imm));
    end
    if (got.chk_imm) check_val("dec_imm", imm, got.imm);
    check_val("dec_we", 64'(rf_we), 64'd0);
    check_val("dec_busy", 64'({busy, imem_req}), 64'd2);
    tick();
    if (got.cause == 2'd3) begin
      check_val("illegal_trap", 64'({trap, trap_cause}), 64'h7);
      check_val("illegal_busy", 64'({busy, rf_we, imem_req}), 64'd0);
      check_val("illegal_pc", pc, got.pc);
      return;
    end
    if (drop_run) run = 1'b0;
    check_val("exec_we", 64'(rf_we), 64'd0);
    tick();
    check_val("wb_we", 64'(rf_we), 64'(got.we));
    check_val("wb_hold_rd", 64'(rf_rd), 64'(got.rd));
    if (got.chk_alu) check_val("wb_hold_op", 64'(alu_opcode), 64'(got.op));
    check_val("wb_pc", pc, got.pc);
    tick();
    check_val("post_we", 64'(rf_we), 64'd0);
    if (got.cause == 2'd2) begin
      check_val("mis_trap", 64'({trap, trap_cause}), 64'h6);
      check_val("mis_pc", pc, got.pc);
      check_val("mis_busy", 64'({busy, imem_req}), 64'd0);
    end else begin
      retired++;
      check_val("next_pc", pc, got.next_pc);
      check_val("next_busy", 64'({busy, imem_req}), 64'({run, run}));
    end
  endtask

  task automatic do_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                      input logic [2:0] f3, input logic [4:0] rd, input logic drop_run);
    exp_t e;
    e = '{default: 0};
    e.pc = model_pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.op = 7'b0110011; e.f3 = f3; e.f7 = f7; e.chk_alu = 1'b1;
    e.we = (rd != 5'd0); e.next_pc = model_pc + 64'd4;
    exec(enc_r(f7, rs2, rs1, f3, rd), e, 1'b0, 0, drop_run);
    model_pc = e.next_pc;
  endtask

  task automatic do_i(input logic [11:0] imm12, input logic [4:0] rs1, input logic [2:0] f3,
                      input logic [4:0] rd, input int delay);
    exp_t e;
    e = '{default: 0};
    e.pc = model_pc; e.rs1 = rs1; e.rs2 = imm12[4:0]; e.rd = rd;
    e.op = 7'b0010011; e.f3 = f3; e.f7 = (f3 == 3'b101) ? imm12[11:5] : 7'd0;
    e.b_imm = 1'b1; e.chk_alu = 1'b1; e.chk_imm = 1'b1;
    e.imm = {{52{imm12[11]}}, imm12};
    e.we = (rd != 5'd0); e.next_pc = model_pc + 64'd4;
    exec(enc_i(imm12, rs1, f3, rd), e, 1'b0, delay, 1'b0);
    model_pc = e.next_pc;
  endtask

  task automatic do_b(input logic [2:0] f3, input int off, input logic zero);
    exp_t        e;
    logic [12:0] o;
    logic [63:0] tgt;
    logic        taken;
    o     = off[12:0];
    e     = '{default: 0};
    taken = (f3 == 3'b000) ? zero : !zero;
    tgt   = model_pc + 64'(longint'(off));
    e.pc = model_pc; e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = {o[4:1], o[11]};
    e.chk_alu = (f3 == 3'b000) || (f3 == 3'b001);
    e.chk_imm = e.chk_alu;
    e.op = 7'b0110011; e.f3 = 3'b000; e.f7 = 7'b0100000;
    e.imm = 64'(longint'(off));
    if (!e.chk_alu) e.cause = 2'd3;
    else if (taken && (tgt[1:0] != 2'b00)) e.cause = 2'd2;
    e.next_pc = taken ? tgt : model_pc + 64'd4;
    exec(enc_b(f3, o), e, zero, 0, 1'b0);
    if (e.cause == 2'd0) model_pc = e.next_pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    do_reset();
    run = 1'b1;
    do_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 1'b0);
    check_val("add_pc", pc, 64'h104);
    do_i(12'd5, 5'd0, 3'b000, 5'd0, 0);
    do_i(12'hFFF, 5'd0, 3'b000, 5'd5, 0);
    check_val("instret_3", instret, exp_instret());
    do_i(12'h403, 5'd1, 3'b101, 5'd6, 0);
    do_i(12'h800, 5'd3, 3'b000, 5'd7, 15);
    do_r(7'b0100000, 5'd5, 5'd4, 3'b000, 5'd7, 1'b0);
    do_b(3'b000, 512 - int'(model_pc[15:0]), 1'b1);
    check_val("beq_to_200", pc, 64'h200);
    do_b(3'b000, 8, 1'b0);
    check_val("beq_nt", pc, 64'h204);
    do_b(3'b001, 8, 1'b1);
    do_b(3'b001, -8, 1'b0);
    check_val("bne_t", pc, 64'h200);
    do_b(3'b000, 8, 1'b1);
    check_val("beq_t", pc, 64'h208);
    do_b(3'b001, -(int'(model_pc[15:0]) + 4), 1'b0);
    check_val("neg_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    do_b(3'b000, 8, 1'b1);
    check_val("wrap_pc", pc, 64'h4);
    do_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 1'b1);
    repeat (3) tick();
    check_val("idle_hold", 64'({busy, imem_req}), 64'd0);
    check_val("idle_pc", pc, 64'h8);
    check_val("instret_all", instret, exp_instret());

    do_reset();
    run = 1'b1;
    do_b(3'b000, 2, 1'b1);
    repeat (3) tick();
    check_val("mis_hold", 64'({trap, trap_cause}), 64'h6);
    check_val("mis_instret", instret, 64'd0);

    do_reset();
    run = 1'b1;
    e = '{default: 0};
    e.pc = RST_PC; e.cause = 2'd3;
    exec(32'h0000007F, e, 1'b0, 0, 1'b0);
    imem_ack = 1'b1;
    repeat (3) tick();
    imem_ack = 1'b0;
    check_val("ill_hold", 64'({trap, trap_cause, imem_req, rf_we}), 64'h1C);

    do_reset();
    check_val("ill_cleared", 64'({trap, trap_cause}), 64'd0);
    run = 1'b1;
    do_b(3'b010, 8, 1'b1);

    do_reset();
    run = 1'b1;
    tick();
    check_val("to_req", 64'(imem_req), 64'd1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check_val("to_wait", 64'({trap, imem_req}), 64'd1);
    end
    tick();
    check_val("to_trap", 64'({trap, trap_cause}), 64'h5);
    check_val("to_idle", 64'({busy, imem_req}), 64'd0);
    check_val("to_pc", pc, RST_PC);

    do_reset();
    run = 1'b1;
    do_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h002081B3;
    tick();
    imem_ack = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    check_val("arst_pc", pc, RST_PC);
    check_val("arst_out", 64'({rf_we, busy, imem_req, trap, rf_rd, alu_opcode}), 64'd0);
    check_val("arst_imm", imm, 64'd0);
    tick();
    check_val("arst_we", 64'(rf_we), 64'd0);
    check_val("arst_instret", instret, 64'd0);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the 64-bit core datapath: ALU, ALU control and the 32x64 register file.
- Owns the program counter and fetches 32-bit instructions over a req/ack handshake.
- Decodes the R-type, I-type ALU and BEQ/BNE subset, and drives the register-file selects, write enable and ALU opcode/func fields in fixed phases.
- Raises a sticky trap on illegal opcode, fetch timeout or misaligned branch target.

Parameters:
- XLEN, 64, datapath and PC width.
- RESET_PC, 64'h0, PC value loaded on reset.
- FETCH_TIMEOUT, 16, maximum FETCH cycles without imem_ack before a trap.

Ports:
- Clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run  in  1  level; allow starting a new instruction.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  32  instruction word.
- rf_rs1, rf_rs2, rf_rd  out  5 each  register-file selects.
- rf_we  out  1  register-file write enable.
- alu_opcode  out  7  to ALU control.
- alu_func3  out  3  to ALU control.
- alu_func7  out  7  to ALU control.
- alu_b_imm  out  1  1 = ALU B operand is imm.
- imm  out  XLEN  sign-extended immediate.
- alu_zero  in  1  ALU Zero flag.
- pc  out  XLEN  current PC.
- busy  out  1  high in any state except IDLE or TRAP.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  0 none, 1 fetch timeout, 2 misaligned target, 3 illegal opcode.
- instret  out  64  retired-instruction count; see Optional Feature.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, TRAP.
- Reset (rst low, asynchronous):
  - state = IDLE, pc = RESET_PC.
  - All other outputs 0; instret 0.
  - In-flight instruction abandoned; no register write occurs.
- IDLE: if run = 1, go to FETCH next cycle.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - Ack in the first request cycle is accepted.
  - On imem_ack: latch imem_rdata, clear the timeout counter, go to DECODE.
  - FETCH_TIMEOUT consecutive cycles without ack: go to TRAP, cause 1.
  - imem_ack outside FETCH is ignored.
- DECODE (1 cycle):
  - Drive rf_rs1 = instr[19:15], rf_rs2 = instr[24:20], rf_rd = instr[11:7]; imm valid.
  - These, and the alu_* fields, are held stable through WB.
  - Opcode not in {0110011, 0010011, 1100011}, or BRANCH with func3 not in {000, 001}: go to TRAP, cause 3.
- Per-class drive:
  - R-type: alu_* = instr fields; alu_b_imm = 0.
  - I-type: alu_opcode = 0010011, func3 = instr[14:12]; alu_b_imm = 1.
    - func7 = instr[31:25] for func3 = 101; 0 otherwise.
    - imm = sext(instr[31:20]).
  - Branch: alu_opcode = 0110011, func3 = 000, func7 = 0100000 (SUB); alu_b_imm = 0.
    - imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- EXEC (1 cycle):
  - ALU fields valid; alu_zero sampled at end of cycle.
  - Taken = (func3 == 000) ? zero : !zero.
- WB (1 cycle):
  - rf_we = 1 only for R/I-type with rd != 0; rf_we = 0 in every other state.
  - pc = pc + 4, or pc + imm for a taken branch; arithmetic modulo 2^64 (wraps).
  - Taken target with bits [1:0] != 0: pc unchanged, go to TRAP, cause 2.
  - Otherwise: next state is FETCH if run = 1, else IDLE.
- run deasserted mid-instruction: the current instruction completes; stop in IDLE after WB.
- Minimum latency: 4 cycles per instruction with zero-wait ack (FETCH, DECODE, EXEC, WB).
- TRAP: held until reset; busy = 0, rf_we = 0, imem_req = 0; pc holds the faulting instruction's address.

Optional Feature:
- Macro INSTR_COUNT_EN.
- Defined: instret increments by 1 on each WB cycle that does not trap, wraps at 2^64, resets to 0.
- Undefined: instret tied to 0 and no counter is synthesised; port list unchanged.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - ctrl_state_e enum;
  - opcode constants OP_RTYPE, OP_ITYPE, OP_BRANCH;
  - trap_cause_e enum;
  - ALU SUB func7 constant.
- Sub-module imm_gen: combinational instr -> I/B sign-extended immediate, selected by opcode.

Test Plan:
- Reset with pc = RESET_PC = 0x100, run = 1, zero-wait ack, instr ADD x3,x1,x2 (0x002081B3): rf_rs1 = 1, rf_rs2 = 2, rf_rd = 3; rf_we pulses 1 cycle in WB (cycle 4); pc = 0x104.
- ADDI x0,x0,5: no rf_we pulse; pc += 4. ADDI x5,x0,-1: imm = 0xFFFF_FFFF_FFFF_FFFF, alu_b_imm = 1.
- BEQ with alu_zero = 1, offset +8 at pc 0x200: pc = 0x208. Same with alu_zero = 0: pc = 0x204. BNE: inverse results.
- Branch at pc 0xFFFF_FFFF_FFFF_FFFC, offset +8: pc wraps to 0x4.
- Opcode 0x7F: trap = 1, cause 3, no rf_we. ack withheld 16 cycles: trap, cause 1. Both clear only after rst low.
- rst pulsed low during EXEC: outputs 0, pc = RESET_PC immediately, no rf_we. With INSTR_COUNT_EN, instret = 3 after three retired instructions; without it, instret = 0.
